// File: rtl/block_key_pkg.sv
// Shared constants and types for the key command generator: key indices,
// channel state encoding and the repeat-counter width helper.
package block_key_pkg;

  localparam int unsigned KEY_NUM   = 4;
  localparam int unsigned KEY_W     = 2;

  localparam int unsigned KEY_LEFT  = 0;
  localparam int unsigned KEY_RIGHT = 1;
  localparam int unsigned KEY_DOWN  = 2;
  localparam int unsigned KEY_ROT   = 3;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_DELAY,
    CH_REPEAT,
    CH_HELD
  } chan_state_t;

  // Counter only ever holds max-1, so clog2(max) bits; keep at least one bit.
  function automatic int unsigned cnt_width(input int unsigned delay_cyc,
                                            input int unsigned rate_cyc);
    int unsigned max_cyc;
    max_cyc = (delay_cyc > rate_cyc) ? delay_cyc : rate_cyc;
    return (max_cyc > 1) ? $clog2(max_cyc) : 1;
  endfunction

endpackage

// File: rtl/key_cmd_gen_if.sv
// Command handshake between the key command generator and the game engine.
interface key_cmd_gen_if;

  logic                            cmd_valid;
  logic [block_key_pkg::KEY_W-1:0] cmd_code;
  logic                            cmd_ready;

  modport master (
    output cmd_valid,
    output cmd_code,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_code,
    output cmd_ready
  );

endinterface

// File: rtl/key_repeat_chan.sv
// Per-key channel: press/release FSM, optional auto-repeat timer and the
// pending-event bit. Auto-repeat is built only when KEY_REPEAT_EN is defined.
module key_repeat_chan
  import block_key_pkg::*;
`ifdef KEY_REPEAT_EN
#(
  parameter int unsigned DELAY_CYC = 1,
  parameter int unsigned RATE_CYC  = 1
)
`endif
(
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic flag,
  input  logic value,
  input  logic pend_clr,
  output logic pend
);

  chan_state_t state_q;
  chan_state_t state_d;
  logic        pend_q;
  logic        pend_set;
  logic        press_ev;
  logic        rel_ev;

  assign press_ev = flag & ~value;
  assign rel_ev   = flag &  value;

`ifdef KEY_REPEAT_EN
  localparam int unsigned      CNT_W    = cnt_width(DELAY_CYC, RATE_CYC);
  localparam logic [CNT_W-1:0] DELAY_LD = CNT_W'(DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] RATE_LD  = CNT_W'(RATE_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= CH_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_set | (pend_q & ~pend_clr);
    end
  end

  // A strobe overrides a timer expiring in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (press_ev) begin
      state_d = CH_DELAY;
      cnt_d   = DELAY_LD;
    end else if (rel_ev) begin
      state_d = CH_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        CH_DELAY: begin
          if (cnt_q == '0) begin
            state_d = CH_REPEAT;
            cnt_d   = RATE_LD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        CH_REPEAT: begin
          if (cnt_q == '0) cnt_d = RATE_LD;
          else             cnt_d = cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pend_set = press_ev
             | (~flag & (state_q inside {CH_DELAY, CH_REPEAT}) & (cnt_q == '0));
  end
`else
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= CH_IDLE;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_set | (pend_q & ~pend_clr);
    end
  end

  always_comb begin
    state_d = state_q;
    if (press_ev)    state_d = CH_HELD;
    else if (rel_ev) state_d = CH_IDLE;
  end

  always_comb begin
    pend_set = press_ev;
  end
`endif

  assign pend = pend_q;

endmodule

// File: rtl/key_cmd_gen.sv
// Key command generator: four key channels feeding a lowest-index-first
// arbiter and a valid/ready output register. Auto-repeat: KEY_REPEAT_EN.
module key_cmd_gen
  import block_key_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned DELAY_MS = 300,
  parameter int unsigned RATE_MS  = 100
)
(
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [KEY_NUM-1:0] key_flag,
  input  logic [KEY_NUM-1:0] key_value,
  key_cmd_gen_if.master      cmd
);

  localparam int unsigned DELAY_CYC = CLK_FREQ / 1000 * DELAY_MS;
  localparam int unsigned RATE_CYC  = CLK_FREQ / 1000 * RATE_MS;

  if (DELAY_CYC < 1 || RATE_CYC < 1) begin : g_cfg_check
    $error("key_cmd_gen: DELAY_CYC and RATE_CYC must each be at least 1");
  end

  logic [KEY_NUM-1:0] pend;
  logic [KEY_NUM-1:0] pend_clr;
  logic               valid_q;
  logic [KEY_W-1:0]   code_q;
  logic [KEY_W-1:0]   sel;
  logic               hit;
  logic               load;

  for (genvar k = 0; k < KEY_NUM; k++) begin : g_chan
`ifdef KEY_REPEAT_EN
    key_repeat_chan #(
      .DELAY_CYC (DELAY_CYC),
      .RATE_CYC  (RATE_CYC)
    ) u_chan (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .flag      (key_flag[k]),
      .value     (key_value[k]),
      .pend_clr  (pend_clr[k]),
      .pend      (pend[k])
    );
`else
    key_repeat_chan u_chan (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .flag      (key_flag[k]),
      .value     (key_value[k]),
      .pend_clr  (pend_clr[k]),
      .pend      (pend[k])
    );
`endif
  end

  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int unsigned i = 0; i < KEY_NUM; i++) begin
      if (pend[i] && !hit) begin
        hit = 1'b1;
        sel = KEY_W'(i);
      end
    end
  end

  // cmd_ready only matters while a command is presented.
  assign load = ~valid_q | cmd.cmd_ready;

  always_comb begin
    pend_clr = '0;
    if (load && hit) pend_clr[sel] = 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      valid_q <= 1'b0;
      code_q  <= '0;
    end else if (load) begin
      valid_q <= hit;
      if (hit) code_q <= sel;
    end
  end

  assign cmd.cmd_valid = valid_q;
  assign cmd.cmd_code  = code_q;

endmodule

// File: tb/tb_key_cmd_gen.sv
// Bench for key_cmd_gen: vector table, directed corner sequences and
// randomized traffic checked against a timestamp-based event model.
module tb_key_cmd_gen;
  import block_key_pkg::*;

  localparam int unsigned D = 3;
  localparam int unsigned R = 2;
`ifdef KEY_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic               sys_clk   = 1'b0;
  logic               sys_rst_n = 1'b0;
  logic [KEY_NUM-1:0] key_flag  = '0;
  logic [KEY_NUM-1:0] key_value = '1;

  key_cmd_gen_if bus ();

  key_cmd_gen #(
    .CLK_FREQ (1000),
    .DELAY_MS (D),
    .RATE_MS  (R)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_flag  (key_flag),
    .key_value (key_value),
    .cmd       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: each key holds the absolute cycle of its next timed event.
  bit                 m_pend [KEY_NUM];
  longint             m_next [KEY_NUM];
  bit                 m_valid;
  int unsigned        m_code;
  longint             cyc = 0;
  logic [KEY_NUM-1:0] set_now;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int k = 0; k < KEY_NUM; k++) begin
        m_pend[k] = 1'b0;
        m_next[k] = -1;
      end
      m_valid = 1'b0;
      m_code  = 0;
    end else begin
      for (int k = 0; k < KEY_NUM; k++) begin
        set_now[k] = 1'b0;
        if (key_flag[k] && !key_value[k]) begin
          set_now[k] = 1'b1;
          m_next[k]  = REP ? cyc + 1 + D : -1;
        end else if (key_flag[k]) begin
          m_next[k] = -1;
        end else if (m_next[k] == cyc + 1) begin
          set_now[k] = 1'b1;
          m_next[k]  = m_next[k] + R;
        end
      end
      if (!m_valid || bus.cmd_ready) begin
        m_valid = 1'b0;
        for (int k = KEY_NUM - 1; k >= 0; k--) begin
          if (m_pend[k]) begin
            m_valid = 1'b1;
            m_code  = k;
          end
        end
        if (m_valid) m_pend[m_code] = 1'b0;
      end
      for (int k = 0; k < KEY_NUM; k++) m_pend[k] = m_pend[k] | set_now[k];
      cyc++;
    end
  end

  bit mon_en = 1'b0;
  always @(negedge sys_clk) begin
    if (mon_en) begin
      chk("mon_valid", bus.cmd_valid, m_valid);
      if (m_valid) chk("mon_code", bus.cmd_code, m_code);
    end
  end

  task automatic step(input logic [3:0] f, input logic [3:0] v, input logic rdy);
    @(posedge sys_clk);
    #1;
    key_flag      = f;
    key_value     = v;
    bus.cmd_ready = rdy;
    @(negedge sys_clk);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(4'b0000, 4'b1111, 1'b1);
  endtask

  typedef struct {
    logic [3:0] flag;
    logic [3:0] value;
    logic       ready;
    logic       exp_valid;
    logic [1:0] exp_code;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n_hs;
    logic [3:0]  f;
    logic        exp_v;

    // Single press/release of RIGHT, then LEFT+ROT together.
    vecs[0]  = '{4'b0010, 4'b0000, 1'b1, 1'b0, 2'd0};
    vecs[1]  = '{4'b0010, 4'b0010, 1'b1, 1'b0, 2'd0};
    vecs[2]  = '{4'b0000, 4'b1111, 1'b1, 1'b1, 2'(KEY_RIGHT)};
    vecs[3]  = '{4'b0000, 4'b1111, 1'b1, 1'b0, 2'd0};
    vecs[4]  = '{4'b0000, 4'b1111, 1'b1, 1'b0, 2'd0};
    vecs[5]  = '{4'b0000, 4'b1111, 1'b1, 1'b0, 2'd0};
    vecs[6]  = '{4'b1001, 4'b0000, 1'b1, 1'b0, 2'd0};
    vecs[7]  = '{4'b1001, 4'b1001, 1'b1, 1'b0, 2'd0};
    vecs[8]  = '{4'b0000, 4'b1111, 1'b1, 1'b1, 2'(KEY_LEFT)};
    vecs[9]  = '{4'b0000, 4'b1111, 1'b1, 1'b1, 2'(KEY_ROT)};
    vecs[10] = '{4'b0000, 4'b1111, 1'b1, 1'b0, 2'd0};
    vecs[11] = '{4'b0000, 4'b1111, 1'b1, 1'b0, 2'd0};

    bus.cmd_ready = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("reset_valid", bus.cmd_valid, 0);
    chk("reset_code", bus.cmd_code, 0);
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    mon_en = 1'b1;
    drain(3);

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].flag, vecs[i].value, vecs[i].ready);
      chk($sformatf("vec%0d_valid", i), bus.cmd_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) chk($sformatf("vec%0d_code", i), bus.cmd_code, vecs[i].exp_code);
    end
    drain(4);

    // Hold DOWN: one command at +2, then repeats at +5, +7, +9, +11 if enabled.
    for (int rel = 0; rel < 12; rel++) begin
      if (rel == 0) step(4'b0100, 4'b0000, 1'b1);
      else          step(4'b0000, 4'b1111, 1'b1);
      exp_v = (rel == 2) || (REP && rel >= 5 && (rel - 5) % 2 == 0);
      chk($sformatf("hold_valid_%0d", rel), bus.cmd_valid, exp_v);
      if (exp_v) chk($sformatf("hold_code_%0d", rel), bus.cmd_code, KEY_DOWN);
    end
    step(4'b0100, 4'b0100, 1'b1);
    drain(8);

    // Backpressure on LEFT for 8 cycles, then exactly one delivery.
    n_hs = 0;
    for (int rel = 0; rel < 15; rel++) begin
      if (rel == 0)      step(4'b0001, 4'b0000, 1'b0);
      else if (rel == 1) step(4'b0001, 4'b0001, 1'b0);
      else               step(4'b0000, 4'b1111, rel >= 10);
      if (rel >= 2 && rel <= 10) begin
        chk($sformatf("bp_valid_%0d", rel), bus.cmd_valid, 1);
        chk($sformatf("bp_code_%0d", rel), bus.cmd_code, KEY_LEFT);
      end else if (rel > 10) begin
        chk($sformatf("bp_idle_%0d", rel), bus.cmd_valid, 0);
      end
      if (bus.cmd_valid && bus.cmd_ready) n_hs++;
    end
    chk("bp_count", n_hs, 1);
    drain(3);

    // Release RIGHT during the initial delay: one command, then silence.
    n_hs = 0;
    for (int rel = 0; rel < 16; rel++) begin
      if (rel == 0)      step(4'b0010, 4'b0000, 1'b1);
      else if (rel == 2) step(4'b0010, 4'b0010, 1'b1);
      else               step(4'b0000, 4'b1111, 1'b1);
      if (bus.cmd_valid && bus.cmd_code == 2'(KEY_RIGHT)) n_hs++;
    end
    chk("mid_delay_count", n_hs, 1);
    chk("mid_delay_idle", bus.cmd_valid, 0);
    drain(3);

    // Reset while DOWN is held (repeating when enabled); key stays held after.
    step(4'b0100, 4'b0000, 1'b1);
    drain(7);
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b0;
    #1;
    chk("rst_now_valid", bus.cmd_valid, 0);
    chk("rst_now_code", bus.cmd_code, 0);
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    n_hs = 0;
    for (int rel = 0; rel < 15; rel++) begin
      step(4'b0000, 4'b1111, 1'b1);
      if (bus.cmd_valid) n_hs++;
    end
    chk("post_reset_silent", n_hs, 0);
    step(4'b0100, 4'b0100, 1'b1);
    drain(3);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        @(posedge sys_clk);
        #1;
        key_flag  = '0;
        sys_rst_n = 1'b0;
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
      end
      f = '0;
      for (int k = 0; k < KEY_NUM; k++) if ($urandom_range(0, 5) == 0) f[k] = 1'b1;
      step(f, 4'($urandom), $urandom_range(0, 3) != 0);
    end
    drain(10);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/key_cmd_gen.md
KEY_CMD_GEN -- requirements
Module: key_cmd_gen

Interface
REQ-001 Parameter CLK_FREQ, 50_000_000, sys_clk frequency in Hz.
REQ-002 Parameter DELAY_MS, 300, hold time before the first auto-repeat.
REQ-003 Parameter RATE_MS, 100, auto-repeat period.
REQ-004 sys_clk  input  1  system clock, all logic on the rising edge.
REQ-005 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-006 key_flag  input  4  per-key one-cycle "debounced value valid" strobe; bit 0 left, 1 right, 2 down, 3 rotate.
REQ-007 key_value  input  4  per-key debounced level; 0 = pressed, 1 = released; sampled only when key_flag is high for that key.
REQ-008 cmd_valid  output  1  a move command is presented.
REQ-009 cmd_code  output  2  key index of the presented command.
REQ-010 cmd_ready  input  1  game engine accepts the command in this cycle.

Function
REQ-011 Each key has an independent channel FSM with states IDLE, DELAY and REPEAT, plus a down-counter and a pending bit.
REQ-012 key_flag=1 with key_value=0 in any state: set pending, load counter with DELAY_CYC-1 (DELAY_CYC = CLK_FREQ/1000*DELAY_MS), go to DELAY.
REQ-013 key_flag=1 with key_value=1: go to IDLE and clear the counter; an already-set pending bit is kept.
REQ-014 DELAY: decrement each cycle; at 0, set pending, load RATE_CYC-1 (RATE_CYC = CLK_FREQ/1000*RATE_MS), go to REPEAT.
REQ-015 REPEAT: decrement each cycle; at 0, set pending and reload RATE_CYC-1.
REQ-016 An event on a key whose pending bit is already set coalesces; there is no event count or overflow.
REQ-017 Output register: when cmd_valid=0, or cmd_valid&cmd_ready in this cycle, load the lowest-index pending key into cmd_code, set cmd_valid and clear that pending bit; if none is pending, cmd_valid goes to 0.
REQ-018 While cmd_valid=1 and cmd_ready=0, cmd_code and cmd_valid remain stable.
REQ-019 Latency: a press strobe in cycle N sets pending in N+1; cmd_valid is asserted in N+2 if the output register is free.
REQ-020 Pending set and clear for the same key in the same cycle: set wins.
REQ-021 cmd_ready is ignored while cmd_valid=0.
REQ-022 Counter width is $clog2(max(DELAY_CYC,RATE_CYC)); DELAY_CYC and RATE_CYC are each at least 1.

Reset
REQ-023 Asserting sys_rst_n low at any time forces all channels to IDLE and clears all counters and pending bits, with cmd_valid=0 and cmd_code=0.
REQ-024 After reset release, no command is generated until a new press strobe arrives, including for keys held through reset.

Configuration
REQ-025 With macro KEY_REPEAT_EN defined, auto-repeat operates as described in REQ-014 and REQ-015.
REQ-026 Without KEY_REPEAT_EN, the DELAY and REPEAT counters are not built: a press goes to a HELD state and produces exactly one event, and a release returns the channel to IDLE.

Structure
REQ-027 Package block_key_pkg holds the key index constants (KEY_LEFT=0, KEY_RIGHT=1, KEY_DOWN=2, KEY_ROT=3), KEY_NUM=4 and the channel state typedef.
REQ-028 The per-key FSM plus counter is a sub-module key_repeat_chan, instantiated KEY_NUM times; arbitration and the output register stay in key_cmd_gen.

Verification
(Bench uses CLK_FREQ=1000, DELAY_MS=3, RATE_MS=2, so 1 ms = 1 cycle.)
REQ-029 Single press: key_flag[1]=1, key_value[1]=0 at cycle 10, cmd_ready=1 -> cmd_valid=1 with cmd_code=1 at cycle 12, for one cycle.
REQ-030 Hold: key 2 pressed at cycle 10 and never released, with KEY_REPEAT_EN -> commands at cycles 12, 15, 17 and 19; without KEY_REPEAT_EN -> only the command at cycle 12.
REQ-031 Backpressure: press on key 0 with cmd_ready=0 for 8 cycles -> cmd_valid=1 and cmd_code=0 held stable; exactly one command is delivered after cmd_ready=1.
REQ-032 Simultaneous: keys 3 and 0 pressed in the same cycle with cmd_ready=1 -> cmd_code=0, then cmd_code=3 in consecutive cycles.
REQ-033 Release mid-delay: press key 1 at cycle 10, release at cycle 12 -> one command only, and the channel ends in IDLE.
REQ-034 Reset mid-repeat: assert sys_rst_n low during REPEAT -> cmd_valid=0 immediately, and no command after release until a new press.
